cfu_l0_initiator: RTL
=====================

Name: cfu_l0_initiator

Overview:
- Requester-side engine for the CFU-L0 interface. It accepts one custom-function request at a time from a CPU pipeline over a valid/ready handshake.
- It drives the registered request onto the CFU-L0 req_* ports and samples resp_* after a fixed CFU_LATENCY. It holds the result for the CPU until the CPU accepts it.
- It sits between the core's execute stage and any CFU-L0 responder, including popcount_cfu (LATENCY 0). It also keeps saturating operation and error counters.

Parameters:
- CFU_LI_VERSION, 0x01000000, CFU-LI version; checked with check_cfu_l0_params at elaboration.
- CFU_N_CFUS, 1, number of CFUs addressable behind this port.
- CFU_CFU_ID_W, 1, width of the cfu id; at least 1.
- CFU_FUNC_ID_W, 10, width of the function id; at least 1.
- CFU_DATA_W, 32, operand/result width; 32 or 64.
- CFU_LATENCY, 0, responder latency in cycles; range 0..7.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- cpu_req_valid  input  1  CPU request valid.
- cpu_req_ready  output  1  initiator can accept a request.
- cpu_req_cfu  input  CFU_CFU_ID_W  target CFU.
- cpu_req_func  input  CFU_FUNC_ID_W  function id.
- cpu_req_data0  input  CFU_DATA_W  operand 0.
- cpu_req_data1  input  CFU_DATA_W  operand 1.
- cpu_resp_valid  output  1  result valid.
- cpu_resp_ready  input  1  CPU accepts the result.
- cpu_resp_status  output  CFU_STATUS_W  result status.
- cpu_resp_data  output  CFU_DATA_W  result data.
- req_valid  output  1  CFU-L0 request valid.
- req_cfu  output  CFU_CFU_ID_W  CFU-L0 cfu id.
- req_func  output  CFU_FUNC_ID_W  CFU-L0 function id.
- req_data0  output  CFU_DATA_W  CFU-L0 operand 0.
- req_data1  output  CFU_DATA_W  CFU-L0 operand 1.
- resp_status  input  CFU_STATUS_W  CFU-L0 status.
- resp_data  input  CFU_DATA_W  CFU-L0 result data.
- n_ops  output  CNT_W  completed operations, saturating.
- n_errs  output  CNT_W  completions with status != CFU_OK, saturating.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE.
  - All outputs 0, except cpu_req_ready = 1 once rst_n is high.
  - req_* registers are 0 and counters are 0.
  - Reset mid-operation abandons the operation; its result is never presented and is never counted.
- States:
  - IDLE: cpu_req_ready = 1.
  - ISSUE: req_valid = 1 for exactly one cycle; req_* come straight from registers and are stable.
  - WAIT: counts down CFU_LATENCY; req_valid = 0 and req_* hold their values.
  - RESP: cpu_resp_valid = 1; status and data are stable until accepted.
- Transitions:
  - IDLE to ISSUE on cpu_req_valid && cpu_req_ready, with cpu_req_cfu < CFU_N_CFUS.
  - ISSUE to RESP when CFU_LATENCY = 0; resp_* are sampled at the end of the ISSUE cycle.
  - ISSUE to WAIT otherwise. WAIT to RESP after CFU_LATENCY cycles; resp_* are sampled in the last WAIT cycle.
  - RESP to IDLE on cpu_resp_ready.
- Latency: request accepted in cycle T, req_valid in T+1, cpu_resp_valid in T+2+CFU_LATENCY.
- Back-to-back: cpu_req_ready = (state==IDLE) || (state==RESP && cpu_resp_ready).
  - A request accepted in the same cycle a result is accepted goes straight from RESP to ISSUE.
  - This gives one operation every 2+CFU_LATENCY cycles.
- Bad cfu id (cpu_req_cfu >= CFU_N_CFUS):
  - No CFU request is issued.
  - The initiator goes IDLE to RESP with status CFU_ERROR_CFU and data 0; cpu_resp_valid appears in T+1.
- Only one operation is outstanding. No cpu_req_valid/ready combinational path is required beyond the ready equation above.
- Counters:
  - Increment at cpu_resp_valid && cpu_resp_ready.
  - n_errs also increments when status != CFU_OK.
  - Both saturate at all-ones, with no wrap.
- cpu_resp_data and status are registered copies; later changes on resp_* do not affect them.
- cpu_req_valid dropping without acceptance has no effect.

Decomposition:
- cfu_pkg holds cfu_status_t, CFU_STATUS_W, CFU_OK and CFU_ERROR_CFU.
- A new initiator state enum, cfu_init_state_t, is added to cfu_pkg.
- The parameter checks reuse check_cfu_l0_params from common_pkg.
- One sub-module, sat_counter #(W), is instanced twice for n_ops and n_errs.

Test Plan:
- LATENCY=0 with a popcount responder model: request data0 = 0xF0F0_0001, cpu_resp_ready held high. Expect req_valid in T+1, cpu_resp_valid in T+2, data = 9, status CFU_OK, n_ops = 1.
- Backpressure: cpu_resp_ready low for 5 cycles. Expect cpu_resp_valid and data held stable, cpu_req_ready = 0, and no second req_valid; after acceptance, state returns to IDLE.
- Back-to-back: 4 requests (0, 0xFFFFFFFF, 1, 0x80000000) with ready always high. Expect results 0, 32, 1, 1 at a 2-cycle cadence and n_ops = 4.
- CFU_N_CFUS=1, cpu_req_cfu = 1: expect no req_valid, cpu_resp_valid in T+1, status CFU_ERROR_CFU, data 0, n_errs = 1.
- CFU_LATENCY=3, responder result delayed 3 cycles: expect cpu_resp_valid at T+5 with the correct data; resp_* glitches before the sample cycle are ignored.
- rst_n low during WAIT: expect all outputs 0 on the next cycle, no cpu_resp_valid afterwards, n_ops = 0, and a new request served normally.

Source files
------------

// File: rtl/cfu_pkg.sv
// CFU-L0 status codes and the initiator state encoding.
package cfu_pkg;

  localparam int CFU_STATUS_W = 3;

  typedef enum logic [CFU_STATUS_W-1:0] {
    CFU_OK           = 3'd0,
    CFU_ERROR_CFU    = 3'd1,
    CFU_ERROR_OP     = 3'd2,
    CFU_ERROR_CUSTOM = 3'd3
  } cfu_status_t;

  typedef enum logic [1:0] {
    CFU_INIT_IDLE  = 2'd0,
    CFU_INIT_ISSUE = 2'd1,
    CFU_INIT_WAIT  = 2'd2,
    CFU_INIT_RESP  = 2'd3
  } cfu_init_state_t;

endpackage

// File: rtl/common_pkg.sv
// Shared elaboration-time helpers for CFU-L0 blocks.
package common_pkg;

  localparam logic [31:0] CFU_LI_VERSION_1_0 = 32'h0100_0000;

  // Rejects parameter sets that a CFU-L0 port cannot carry.
  function automatic bit check_cfu_l0_params(
    input int unsigned version,
    input int unsigned n_cfus,
    input int unsigned cfu_id_w,
    input int unsigned func_id_w,
    input int unsigned data_w,
    input int unsigned latency
  );
    return (version == CFU_LI_VERSION_1_0) &&
           (cfu_id_w >= 1) && (cfu_id_w <= 16) &&
           (n_cfus >= 1) && (n_cfus <= (32'd1 << cfu_id_w)) &&
           (func_id_w >= 1) &&
           ((data_w == 32) || (data_w == 64)) &&
           (latency <= 7);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cfu_l0_initiator.sv
// Requester-side CFU-L0 engine: one outstanding custom-function op, fixed-latency
// response capture, result held for the CPU, saturating op/error counters.
module cfu_l0_initiator
  import cfu_pkg::*;
  import common_pkg::*;
#(
  parameter logic [31:0] CFU_LI_VERSION = 32'h0100_0000,
  parameter int          CFU_N_CFUS     = 1,
  parameter int          CFU_CFU_ID_W   = 1,
  parameter int          CFU_FUNC_ID_W  = 10,
  parameter int          CFU_DATA_W     = 32,
  parameter int          CFU_LATENCY    = 0,
  parameter int          CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req_valid,
  output logic                     cpu_req_ready,
  input  logic [CFU_CFU_ID_W-1:0]  cpu_req_cfu,
  input  logic [CFU_FUNC_ID_W-1:0] cpu_req_func,
  input  logic [CFU_DATA_W-1:0]    cpu_req_data0,
  input  logic [CFU_DATA_W-1:0]    cpu_req_data1,
  output logic                     cpu_resp_valid,
  input  logic                     cpu_resp_ready,
  output logic [CFU_STATUS_W-1:0]  cpu_resp_status,
  output logic [CFU_DATA_W-1:0]    cpu_resp_data,
  output logic                     req_valid,
  output logic [CFU_CFU_ID_W-1:0]  req_cfu,
  output logic [CFU_FUNC_ID_W-1:0] req_func,
  output logic [CFU_DATA_W-1:0]    req_data0,
  output logic [CFU_DATA_W-1:0]    req_data1,
  input  logic [CFU_STATUS_W-1:0]  resp_status,
  input  logic [CFU_DATA_W-1:0]    resp_data,
  output logic [CNT_W-1:0]         n_ops,
  output logic [CNT_W-1:0]         n_errs
);

  localparam bit PARAMS_OK = check_cfu_l0_params(CFU_LI_VERSION, CFU_N_CFUS,
    CFU_CFU_ID_W, CFU_FUNC_ID_W, CFU_DATA_W, CFU_LATENCY);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("cfu_l0_initiator: unsupported CFU-L0 parameter set");
    end
  endgenerate

  localparam logic [CFU_CFU_ID_W:0] N_CFUS   = CFU_N_CFUS[CFU_CFU_ID_W:0];
  localparam logic [2:0]            LAT_LAST = 3'(CFU_LATENCY - 1);

  // Handshakes: a transfer happens on a clk edge where valid && ready are both
  // high; valid never waits on ready, and ready may depend on cpu_resp_ready.
  cfu_init_state_t             state;
  logic [2:0]                  lat_cnt;
  logic [CFU_STATUS_W-1:0]     status_q;
  logic [CFU_DATA_W-1:0]       data_q;
  logic                        resp_take;
  logic                        accept;
  logic                        cfu_ok;
  logic                        err_inc;

  assign resp_take     = (state == CFU_INIT_RESP) && cpu_resp_ready;
  assign cpu_req_ready = rst_n && ((state == CFU_INIT_IDLE) || resp_take);
  assign accept        = cpu_req_valid && cpu_req_ready;
  assign cfu_ok        = ({1'b0, cpu_req_cfu} < N_CFUS);
  assign err_inc       = resp_take && (status_q != CFU_OK);

  assign req_valid       = (state == CFU_INIT_ISSUE);
  assign cpu_resp_valid  = (state == CFU_INIT_RESP);
  assign cpu_resp_status = status_q;
  assign cpu_resp_data   = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CFU_INIT_IDLE;
      lat_cnt   <= '0;
      req_cfu   <= '0;
      req_func  <= '0;
      req_data0 <= '0;
      req_data1 <= '0;
      status_q  <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        CFU_INIT_IDLE, CFU_INIT_RESP: begin
          if (accept) begin
            if (cfu_ok) begin
              state     <= CFU_INIT_ISSUE;
              req_cfu   <= cpu_req_cfu;
              req_func  <= cpu_req_func;
              req_data0 <= cpu_req_data0;
              req_data1 <= cpu_req_data1;
            end else begin
              // Unknown CFU: answer locally, nothing reaches the CFU-L0 port.
              state    <= CFU_INIT_RESP;
              status_q <= CFU_ERROR_CFU;
              data_q   <= '0;
            end
          end else if (resp_take) begin
            state <= CFU_INIT_IDLE;
          end
        end
        CFU_INIT_ISSUE: begin
          if (CFU_LATENCY == 0) begin
            state    <= CFU_INIT_RESP;
            status_q <= resp_status;
            data_q   <= resp_data;
          end else begin
            state   <= CFU_INIT_WAIT;
            lat_cnt <= LAT_LAST;
          end
        end
        CFU_INIT_WAIT: begin
          if (lat_cnt == 3'd0) begin
            state    <= CFU_INIT_RESP;
            status_q <= resp_status;
            data_q   <= resp_data;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: state <= CFU_INIT_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_ops_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resp_take),
    .count (n_ops)
  );

  sat_counter #(.W(CNT_W)) u_errs_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .count (n_errs)
  );

endmodule
